// File: rtl/convnet_pkg.sv
// convnet_pkg: types and constants shared by the pooling stage.
//   - pool_state_t : FSM encoding for relu_maxpool
//   - *_DEF        : default geometry and element width
//   - out_dim/idx_w: helpers for pooled edge length and index widths
package convnet_pkg;

  localparam int WIDTH_BIT_DEF = 16;
  localparam int SIZE_IN_DEF   = 6;
  localparam int POOL_DEF      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } pool_state_t;

  // Pooled edge length; trailing rows/columns that do not fill a window drop out.
  function automatic int out_dim(input int size_in, input int pool);
    return size_in / pool;
  endfunction

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OUT_DEF = out_dim(SIZE_IN_DEF, POOL_DEF);

endpackage

// File: rtl/pool_window_ctr.sv
// pool_window_ctr: window row/column and in-window element counters.
// Ports:
//   clock, nreset        : clock, async active-low reset
//   clr_i                : zero all counters (new matrix)
//   step_elem_i          : advance to the next element of the window
//   next_win_i           : move to the next window in row-major order, elem back to 0
//   win_r_o, win_c_o     : current window coordinates
//   elem_o               : element index inside the window (0..POOL*POOL-1)
//   last_elem_o          : elem_o is the final element of the window
//   last_win_o           : current window is (OUT-1, OUT-1)
module pool_window_ctr
  import convnet_pkg::*;
#(
  parameter  int POOL = POOL_DEF,
  parameter  int OUT  = OUT_DEF,
  localparam int RW   = idx_w(OUT),
  localparam int EW   = idx_w(POOL * POOL)
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clr_i,
  input  logic          step_elem_i,
  input  logic          next_win_i,
  output logic [RW-1:0] win_r_o,
  output logic [RW-1:0] win_c_o,
  output logic [EW-1:0] elem_o,
  output logic          last_elem_o,
  output logic          last_win_o
);

  logic [RW-1:0] win_r_q, win_r_d;
  logic [RW-1:0] win_c_q, win_c_d;
  logic [EW-1:0] elem_q,  elem_d;

  // Next-state for the counters; clear has priority over stepping.
  always_comb begin
    win_r_d = win_r_q;
    win_c_d = win_c_q;
    elem_d  = elem_q;
    if (clr_i) begin
      win_r_d = '0;
      win_c_d = '0;
      elem_d  = '0;
    end else if (step_elem_i) begin
      elem_d = elem_q + EW'(1);
    end else if (next_win_i) begin
      elem_d = '0;
      if (win_c_q == RW'(OUT - 1)) begin
        win_c_d = '0;
        win_r_d = win_r_q + RW'(1);
      end else begin
        win_c_d = win_c_q + RW'(1);
      end
    end else begin
      elem_d = elem_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      win_r_q <= '0;
      win_c_q <= '0;
      elem_q  <= '0;
    end else begin
      win_r_q <= win_r_d;
      win_c_q <= win_c_d;
      elem_q  <= elem_d;
    end
  end

  assign win_r_o     = win_r_q;
  assign win_c_o     = win_c_q;
  assign elem_o      = elem_q;
  assign last_elem_o = (elem_q == EW'(POOL * POOL - 1));
  assign last_win_o  = (win_r_q == RW'(OUT - 1)) && (win_c_q == RW'(OUT - 1));

endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU fused with POOLxPOOL max-pooling (stride POOL) over a
// SIZE_IN x SIZE_IN signed matrix, one element compared per cycle, one
// pooled result per valid/ready handshake.
// Ports:
//   clock, nreset     : clock, async active-low reset
//   start             : one-cycle pulse, captures inMatrix (accepted only when idle)
//   inMatrix          : flat matrix, element (i,j) at [(i*SIZE_IN+j)*WIDTH_BIT +: WIDTH_BIT]
//   busy              : scanning or emitting
//   out_valid/ready   : result handshake
//   out_data          : max(0, window max)
//   out_row, out_col  : window coordinates of out_data
//   done              : one-cycle pulse after the last result is accepted
module relu_maxpool
  import convnet_pkg::*;
#(
  parameter  int SIZE_IN   = SIZE_IN_DEF,
  parameter  int POOL      = POOL_DEF,
  parameter  int WIDTH_BIT = WIDTH_BIT_DEF,
  localparam int OUT       = out_dim(SIZE_IN, POOL),
  localparam int RW        = idx_w(OUT)
) (
  input  logic                                  clock,
  input  logic                                  nreset,
  input  logic                                  start,
  input  logic [SIZE_IN*SIZE_IN*WIDTH_BIT-1:0]  inMatrix,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [WIDTH_BIT-1:0]           out_data,
  output logic [RW-1:0]                         out_row,
  output logic [RW-1:0]                         out_col,
  output logic                                  done
);

  localparam int EW = idx_w(POOL * POOL);
  localparam int AW = idx_w(SIZE_IN * SIZE_IN);

  pool_state_t state_q, state_d;

  logic signed [WIDTH_BIT-1:0] buf_q [SIZE_IN*SIZE_IN];
  logic signed [WIDTH_BIT-1:0] acc_q, acc_d;
  logic signed [WIDTH_BIT-1:0] out_data_q, out_data_d;
  logic [RW-1:0]               out_row_q, out_row_d;
  logic [RW-1:0]               out_col_q, out_col_d;
  logic                        busy_q, busy_d;
  logic                        out_valid_q, out_valid_d;
  logic                        done_q, done_d;

  logic                        capture_s, step_elem_s, next_win_s;
  logic [RW-1:0]               win_r_s, win_c_s;
  logic [EW-1:0]               elem_s;
  logic                        last_elem_s, last_win_s;
  int                          rd_row_s, rd_col_s;
  logic [AW-1:0]               rd_idx_s;
  logic signed [WIDTH_BIT-1:0] elem_val_s, max_s;

  pool_window_ctr #(
    .POOL (POOL),
    .OUT  (OUT)
  ) u_ctr (
    .clock       (clock),
    .nreset      (nreset),
    .clr_i       (capture_s),
    .step_elem_i (step_elem_s),
    .next_win_i  (next_win_s),
    .win_r_o     (win_r_s),
    .win_c_o     (win_c_s),
    .elem_o      (elem_s),
    .last_elem_o (last_elem_s),
    .last_win_o  (last_win_s)
  );

  // Address of the element under the cursor and the running signed max.
  always_comb begin
    rd_row_s   = int'(win_r_s) * POOL + int'(elem_s) / POOL;
    rd_col_s   = int'(win_c_s) * POOL + int'(elem_s) % POOL;
    rd_idx_s   = AW'(rd_row_s * SIZE_IN + rd_col_s);
    elem_val_s = buf_q[rd_idx_s];
    if (elem_val_s > acc_q) begin
      max_s = elem_val_s;
    end else begin
      max_s = acc_q;
    end
  end

  // Matrix buffer: no reset needed, every start overwrites all of it.
  always_ff @(posedge clock) begin
    if (capture_s) begin
      for (int i = 0; i < SIZE_IN * SIZE_IN; i++) begin
        buf_q[i] <= inMatrix[i*WIDTH_BIT +: WIDTH_BIT];
      end
    end
  end

  // FSM next-state and datapath next values. acc restarts at 0 each window,
  // so the max already clamps negatives (ReLU).
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    capture_s   = 1'b0;
    step_elem_s = 1'b0;
    next_win_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          acc_d     = '0;
          state_d   = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        acc_d = max_s;
        if (last_elem_s) begin
          out_data_d = max_s;
          out_row_d  = win_r_s;
          out_col_d  = win_c_s;
          state_d    = ST_EMIT;
        end else begin
          step_elem_s = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last_win_s) begin
            state_d = ST_DONE;
          end else begin
            next_win_s = 1'b1;
            acc_d      = '0;
            state_d    = ST_SCAN;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status outputs are registered copies of the next state.
    busy_d      = (state_d == ST_SCAN) || (state_d == ST_EMIT);
    out_valid_d = (state_d == ST_EMIT);
    done_d      = (state_d == ST_DONE);
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign done      = done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed scoreboard bench for relu_maxpool (6x6, 2x2, 16 bit).
module tb_relu_maxpool;

  localparam int SZ = 6;
  localparam int W  = 16;

  logic                 clock = 1'b0;
  logic                 nreset = 1'b0;
  logic                 start = 1'b0;
  logic                 out_ready = 1'b1;
  logic [SZ*SZ*W-1:0]   mat = '0;
  logic                 busy, out_valid, done;
  logic signed [W-1:0]  out_data;
  logic [1:0]           out_row, out_col;

  relu_maxpool dut (
    .clock     (clock),
    .nreset    (nreset),
    .start     (start),
    .inMatrix  (mat),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   start_cyc = 0;
  int   exp_done = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;

  // Hand-computed window maxima of the ramp 6i+j: element (2r+1, 2c+1).
  int ramp_exp [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clock) begin
    if (nreset) begin
      if (out_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: data=%0d row=%0d col=%0d with empty scoreboard", out_data, out_row, out_col);
        end else begin
          e = sb[0];
          if (out_data !== e.data || out_row !== e.row || out_col !== e.col) begin
            n_err++;
            $display("FAIL result: got data=%0d (%0d,%0d) want data=%0d (%0d,%0d)",
                     out_data, out_row, out_col, $signed(e.data), e.row, e.col);
          end
          if (out_ready) begin
            n_vec++;
            if ((cyc - start_cyc) != e.cyc) begin
              n_err++;
              $display("FAIL accept_cycle: got %0d want %0d", cyc - start_cyc, e.cyc);
            end
            void'(sb.pop_front());
          end
        end
      end
      if (done) begin
        done_seen = 1;
        n_vec++;
        if ((cyc - start_cyc) != exp_done) begin
          n_err++;
          $display("FAIL done_cycle: got %0d want %0d", cyc - start_cyc, exp_done);
        end
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_in_done: got %0b want 0", busy);
        end
      end
      if (prev_done) begin
        n_vec++;
        if (done !== 1'b0) begin
          n_err++;
          $display("FAIL done_width: got %0b want 0 one cycle after done", done);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic set_el(input int i, input int j, input logic [15:0] v);
    mat[(i*SZ+j)*W +: W] = v;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++)
        set_el(i, j, 16'(6 * i + j));
  endtask

  task automatic push(input int k, input logic [15:0] d, input int stall);
    exp_t x;
    x.data = d;
    x.row  = 2'(k / 3);
    x.col  = 2'(k % 3);
    x.cyc  = 5 + 5 * k + stall;
    sb.push_back(x);
  endtask

  task automatic push_ramp(input int stall);
    for (int k = 0; k < 9; k++) push(k, 16'(ramp_exp[k]), stall);
    exp_done = 46 + stall;
  endtask

  task automatic fire();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    done_seen = 0;
    while (done_seen == 0 && n < 300) begin
      tick();
      n++;
    end
    n_vec++;
    if (done_seen == 0) begin
      n_err++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", name, n);
    end
    chk({name, "_leftover"}, 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
  endtask

  initial begin
    // Power-on reset.
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    nreset = 1'b1;
    repeat (2) tick();

    // Ramp, no backpressure.
    load_ramp();
    push_ramp(0);
    fire();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done("ramp");

    // All negative: -1 and most-negative interleaved.
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++)
        set_el(i, j, ((i + j) % 2 == 1) ? 16'h8000 : 16'hFFFF);
    for (int k = 0; k < 9; k++) push(k, 16'd0, 0);
    exp_done = 46;
    fire();
    wait_done("neg");

    // Mixed extremes in window (0,0), zeros elsewhere.
    mat = '0;
    set_el(0, 0, 16'hFFFB);
    set_el(0, 1, 16'h0003);
    set_el(1, 0, 16'h7FFF);
    set_el(1, 1, 16'h8000);
    push(0, 16'h7FFF, 0);
    for (int k = 1; k < 9; k++) push(k, 16'd0, 0);
    exp_done = 46;
    fire();
    wait_done("mixed");

    // Backpressure: ready low through cycle 7, window (0,0) held 3 cycles.
    load_ramp();
    push_ramp(3);
    out_ready = 1'b0;
    fire();
    repeat (7) tick();
    out_ready = 1'b1;
    wait_done("bp");

    // Second start while busy with a different matrix must be ignored.
    load_ramp();
    push_ramp(0);
    fire();
    repeat (7) tick();
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++)
        set_el(i, j, 16'd100);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart");

    // Reset mid-run: outputs clear immediately, nothing until a new start.
    load_ramp();
    push_ramp(0);
    fire();
    repeat (11) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_row", 32'(out_row), 32'd0);
    chk("mid_rst_col", 32'(out_col), 32'd0);
    sb.delete();
    tick();
    nreset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // Recovery after reset.
    push_ramp(0);
    fire();
    wait_done("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, on ports named clock and nreset.
REQ-002 Parameter SIZE_IN, 6, edge length of the square convolution result (SIZE-SIZEKer+1).
REQ-003 Parameter POOL, 2, edge length of the pooling window and the stride.
REQ-004 Parameter WIDTH_BIT, 16, signed element width.
REQ-005 The ports SHALL be:
- clock  in  1  rising-edge clock
- nreset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; capture inMatrix (driven from the conv stage's done)
- inMatrix  in  SIZE_IN x SIZE_IN x WIDTH_BIT signed  convolution output matrix
- busy  out  1  high from the cycle after start is accepted until done
- out_valid  out  1  pooled result available
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH_BIT signed  ReLU(max of window), always >= 0
- out_row, out_col  out  $clog2(OUT) each  window coordinates, where OUT = SIZE_IN/POOL (floor)
- done  out  1  one-cycle pulse after the last result is accepted

Function
REQ-006 The FSM SHALL have four states: IDLE, SCAN, EMIT and DONE.
REQ-007 In IDLE, start=1 SHALL copy inMatrix into an internal buffer, clear win_r, win_c, elem and acc to 0, and go to SCAN.
REQ-008 start SHALL be ignored in any state other than IDLE, and inMatrix changes after capture SHALL have no effect.
REQ-009 SCAN SHALL read one element per cycle, buffer[win_r*POOL + elem/POOL][win_c*POOL + elem%POOL], with elem running 0..POOL*POOL-1, and set acc = max(acc, element) as a signed comparison.
REQ-010 Because acc starts each window at 0, the window result SHALL equal max(0, window max), which implements ReLU with no separate stage.
REQ-011 After elem = POOL*POOL-1 the FSM SHALL register acc into out_data, register win_r/win_c into out_row/out_col, and go to EMIT.
REQ-012 In EMIT, out_valid SHALL be 1 and out_data, out_row and out_col SHALL hold stable until out_valid and out_ready are both 1 (handshake).
REQ-013 On handshake, when the window is not the last one, the FSM SHALL advance in row-major order (win_c+1, wrapping to 0 with win_r+1), clear elem and acc, and return to SCAN.
REQ-014 On handshake of the last window (OUT-1, OUT-1), the FSM SHALL go to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle and then return to IDLE; busy SHALL be 0 in DONE.
REQ-016 Latency: with start in cycle 0, the first out_valid SHALL be in cycle POOL*POOL+1, and each window SHALL take POOL*POOL+1 cycles when out_ready=1.
REQ-017 When SIZE_IN % POOL != 0, trailing rows and columns SHALL be ignored.
REQ-018 No arithmetic overflow is possible (compare-only), and out_data SHALL lie in 0..2^(WIDTH_BIT-1)-1.

Reset
REQ-019 When nreset=0, the state SHALL go to IDLE and busy, out_valid, done, out_data, out_row, out_col and all counters and acc SHALL be 0, regardless of the current state.
REQ-020 Buffer contents after reset are don't-care, and the next start SHALL fully overwrite them.

Structure
REQ-021 A shared package convnet_pkg SHALL hold the FSM state enum type, the default WIDTH_BIT, and the OUT/index-width helper constants.
REQ-022 One sub-module, pool_window_ctr, SHALL hold the win_r/win_c/elem counters and the last-window/last-element flags; the compare logic SHALL stay in relu_maxpool.

Verification
REQ-023 Reset: assert nreset=0 mid-run -> all outputs 0 in the same cycle; after release, out_valid stays 0 until a new start.
REQ-024 Ramp: inMatrix[i][j] = 6i+j, out_ready=1, start in cycle 0 -> outputs 7,9,11,19,21,23,31,33,35 with out_valid in cycles 5,10,...,45 and done in cycle 46.
REQ-025 All-negative input: every element = -1 or 16'sh8000 -> all nine out_data = 0 and done is still produced.
REQ-026 Mixed window (0,0) = {-5, 3, 32767, -32768} -> out_data = 32767 at (0,0).
REQ-027 Backpressure: out_ready=0 for 3 cycles during window (0,0) -> out_data/out_row/out_col stay stable and done moves from cycle 46 to cycle 49.
REQ-028 start pulsed while busy with a different matrix -> ignored; results match the first matrix.
